// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions: register-address width, stage-record layout
// and the bubble value used by the hazard scoreboard and its stage registers.
package hazard_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;

  // Record layout, MSB first: valid, RegWrite, MemRead, addr.
  typedef struct packed {
    logic                  valid;
    logic                  RegWrite;
    logic                  MemRead;
    logic [REG_ADDR_W-1:0] addr;
  } stage_rec_t;

  // Control bits that sit above the address field in every record.
  localparam int REC_CTRL_W = 3;

  localparam stage_rec_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/hazard_stage_reg.sv
// One resettable pipeline stage record. Records are flat vectors laid out like
// stage_rec_t so the address width can follow the parent's parameter.
module hazard_stage_reg
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW = REG_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AW+REC_CTRL_W-1:0] rec_i,
  output logic [AW+REC_CTRL_W-1:0] rec_o
);

  localparam int W = AW + REC_CTRL_W;
  localparam logic [W-1:0] BUBBLE = W'(STAGE_BUBBLE);

  logic [W-1:0] rec_q;

  always_ff @(posedge clk) begin
    if (rst) rec_q <= BUBBLE;
    else     rec_q <= rec_i;
  end

  assign rec_o = rec_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks EX/MEM/WB writers, raises stall
// for load-use and branch-operand hazards, and counts stalled cycles.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = hazard_scoreboard_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [REG_ADDR_W-1:0]    id_RegSrcA,
  input  logic [REG_ADDR_W-1:0]    id_RegSrcB,
  input  logic                     id_UseA,
  input  logic                     id_UseB,
  input  logic                     id_RegWrite,
  input  logic                     id_MemRead,
  input  logic                     id_Branch,
  input  logic [REG_ADDR_W-1:0]    id_RegWriteaddr,
  input  logic                     flush,
  output logic                     ex_RegWrite,
  output logic                     mem_RegWrite,
  output logic                     wb_RegWrite,
  output logic [REG_ADDR_W-1:0]    ex_RegWriteaddr,
  output logic [REG_ADDR_W-1:0]    mem_RegWriteaddr,
  output logic [REG_ADDR_W-1:0]    wb_RegWriteaddr,
  output logic                     stall,
  output logic [2**REG_ADDR_W-1:0] pending,
  output logic [CNT_W-1:0]         stall_cnt
);

  import hazard_scoreboard_pkg::*;

  localparam int REC_W  = REG_ADDR_W + REC_CTRL_W;
  localparam int V_BIT  = REC_W - 1;
  localparam int RW_BIT = REC_W - 2;
  localparam int MR_BIT = REC_W - 3;
  localparam logic [REC_W-1:0] BUBBLE = REC_W'(STAGE_BUBBLE);

  logic [REC_W-1:0] id_rec, ex_d, ex_q, mem_q, wb_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic             load_id;
  logic             ex_wr, mem_wr, wb_wr, mem_ld;
  logic [REG_ADDR_W-1:0] ex_addr, mem_addr, wb_addr;
  logic             ex_hit, mem_hit, load_use, branch_haz;
  logic             wb_mr_unused;

  function automatic logic reads_reg(input logic [REG_ADDR_W-1:0] r,
                                     input logic use_a, input logic [REG_ADDR_W-1:0] src_a,
                                     input logic use_b, input logic [REG_ADDR_W-1:0] src_b);
    return (r != '0) && ((use_a && (src_a == r)) || (use_b && (src_b == r)));
  endfunction

  assign id_rec  = {1'b1, id_RegWrite, id_MemRead, id_RegWriteaddr};
  assign load_id = id_valid & ~flush & ~stall;
  assign ex_d    = load_id ? id_rec : BUBBLE;

  // Stage records: EX <- ID or bubble, MEM <- EX, WB <- MEM on every edge.
  hazard_stage_reg #(.AW(REG_ADDR_W)) u_ex  (.clk(clk), .rst(rst), .rec_i(ex_d),  .rec_o(ex_q));
  hazard_stage_reg #(.AW(REG_ADDR_W)) u_mem (.clk(clk), .rst(rst), .rec_i(ex_q),  .rec_o(mem_q));
  hazard_stage_reg #(.AW(REG_ADDR_W)) u_wb  (.clk(clk), .rst(rst), .rec_i(mem_q), .rec_o(wb_q));

  assign ex_wr    = ex_q[V_BIT]  & ex_q[RW_BIT];
  assign mem_wr   = mem_q[V_BIT] & mem_q[RW_BIT];
  assign wb_wr    = wb_q[V_BIT]  & wb_q[RW_BIT];
  assign mem_ld   = mem_wr & mem_q[MR_BIT];
  assign ex_addr  = ex_q[V_BIT]  ? ex_q[REG_ADDR_W-1:0]  : '0;
  assign mem_addr = mem_q[V_BIT] ? mem_q[REG_ADDR_W-1:0] : '0;
  assign wb_addr  = wb_q[V_BIT]  ? wb_q[REG_ADDR_W-1:0]  : '0;
  assign wb_mr_unused = wb_q[MR_BIT];

  assign ex_hit  = ex_wr & reads_reg(ex_addr, id_UseA, id_RegSrcA, id_UseB, id_RegSrcB);
  assign mem_hit = mem_ld & reads_reg(mem_addr, id_UseA, id_RegSrcA, id_UseB, id_RegSrcB);

  // A branch resolves in ID, so it also waits on any EX writer and on a load in MEM.
  assign load_use   = ex_hit & ex_q[MR_BIT];
  assign branch_haz = id_Branch & (ex_hit | mem_hit);
  assign stall      = id_valid & (load_use | branch_haz) & ~flush;

  always_comb begin
    pending = '0;
    if (ex_wr  && ex_addr  != '0) pending[ex_addr]  = 1'b1;
    if (mem_wr && mem_addr != '0) pending[mem_addr] = 1'b1;
    if (wb_wr  && wb_addr  != '0) pending[wb_addr]  = 1'b1;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign ex_RegWrite      = ex_wr;
  assign mem_RegWrite     = mem_wr;
  assign wb_RegWrite      = wb_wr;
  assign ex_RegWriteaddr  = ex_addr;
  assign mem_RegWriteaddr = mem_addr;
  assign wb_RegWriteaddr  = wb_addr;
  assign stall_cnt        = stall_cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter REG_ADDR_W, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning stall-counter width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port id_valid  input  1  an instruction is present in ID.
REQ-006 The block SHALL have port id_RegSrcA, id_RegSrcB  input  REG_ADDR_W each  ID source registers (ins[25:21], ins[20:16]).
REQ-007 The block SHALL have port id_UseA, id_UseB  input  1 each  ID instruction actually reads that source.
REQ-008 The block SHALL have port id_RegWrite, id_MemRead, id_Branch  input  1 each  ID control bits.
REQ-009 The block SHALL have port id_RegWriteaddr  input  REG_ADDR_W  ID destination register.
REQ-010 The block SHALL have port flush  input  1  the ID instruction is squashed (taken branch/jump).
REQ-011 The block SHALL have ports ex_RegWrite, mem_RegWrite, wb_RegWrite  output  1 each  per-stage writer flags fed to the forwarding unit.
REQ-012 The block SHALL have ports ex_RegWriteaddr, mem_RegWriteaddr, wb_RegWriteaddr  output  REG_ADDR_W each  per-stage destination addresses.
REQ-013 The block SHALL have port stall  output  1  hold PC and IF/ID; insert a bubble into EX.
REQ-014 The block SHALL have port pending  output  2**REG_ADDR_W  bit r set when any in-flight stage will write register r.
REQ-015 The block SHALL have port stall_cnt  output  CNT_W  count of cycles with stall asserted.

Function
REQ-016 The block SHALL hold three stage records EX, MEM, WB, each {valid, RegWrite, MemRead, addr}.
REQ-017 On every non-reset edge the block SHALL shift WB<=MEM and MEM<=EX.
REQ-018 On that edge EX SHALL load the ID record when id_valid & ~flush & ~stall; otherwise EX SHALL load a bubble (all fields 0).
REQ-019 Stage outputs SHALL be taken directly from the stage registers; RegWrite out = valid & RegWrite; addr out = 0 for a bubble.
REQ-020 A register match SHALL require a nonzero address; register 0 never causes a hazard and never sets pending.
REQ-021 Load-use hazard: EX valid & MemRead & RegWrite & addr matches (id_UseA & id_RegSrcA) or (id_UseB & id_RegSrcB).
REQ-022 Branch hazard: id_Branch & one of the following matches a used ID source: (a) EX RegWrite of any kind, or (b) MEM load.
REQ-023 stall SHALL be combinational and equal id_valid & (load-use | branch hazard) & ~flush.
REQ-024 A load hazard SHALL yield exactly one stall cycle; a branch behind an EX load SHALL yield two consecutive stall cycles.
REQ-025 pending[r] SHALL be the OR over valid RegWrite stages with addr==r, r!=0.
REQ-026 stall_cnt SHALL increment by 1 on each edge where stall=1 and SHALL saturate at all-ones.
REQ-027 Simultaneous flush and hazard: flush wins; stall=0, EX gets a bubble, and stall_cnt does not increment.

Reset
REQ-028 While rst=1 at an edge, all stage records SHALL clear to bubble and stall_cnt SHALL clear to 0, overriding all other inputs.
REQ-029 After reset, all outputs SHALL be 0 (stall=0 because every stage is empty).
REQ-030 Reset asserted mid-stall SHALL drop stall on the following cycle, with no residual stall cycles.

Structure
REQ-031 REG_ADDR_W, the stage-record field layout and the bubble constant SHALL live in the shared pipeline package/header.
REQ-032 One sub-module, hazard_stage_reg, SHALL implement a single resettable stage record; it SHALL be instantiated three times.

Verification
REQ-033 Test: lw $8 in ID, then add $9,$8,$1 → one stall cycle; EX bubble; stall_cnt=1; after the stall, mem_RegWriteaddr=8, mem_RegWrite=1.
REQ-034 Test: add $5 then beq $5,$0 → one stall cycle (EX writer).
REQ-035 Test: lw $5 then beq $5,$0 → two stall cycles; stall_cnt=2.
REQ-036 Test: lw $0 then add $2,$0,$0 → no stall; pending=0.
REQ-037 Test: load-use hazard with flush=1 in the same cycle → stall=0; EX bubble; stall_cnt unchanged.
REQ-038 Test: stall_cnt preloaded near all-ones by forcing 2**CNT_W stalls (CNT_W=4 build) → holds at 15; rst mid-stall → all outputs 0 on the next cycle.
